// File: rtl/mul_issue_queue.sv
// Out-of-order issue buffer in front of the pipelined multiply unit.
// Holds renamed multiply uops until both operands are captured, then issues
// the oldest ready uop one per cycle. Mispredict flushes drop every uop whose
// sequence number is younger than the branch.
module mul_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int NUM_WB = 2,
    parameter int TAG_W  = 7,
    parameter int SQN_W  = 7,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IN_valid,
    input  logic [5:0]              IN_opcode,
    input  logic [31:0]             IN_srcA,
    input  logic [31:0]             IN_srcB,
    input  logic [TAG_W-1:0]        IN_tagA,
    input  logic [TAG_W-1:0]        IN_tagB,
    input  logic                    IN_availA,
    input  logic                    IN_availB,
    input  logic [TAG_W-1:0]        IN_tagDst,
    input  logic [4:0]              IN_nmDst,
    input  logic [SQN_W-1:0]        IN_sqN,
    output logic                    OUT_full,
    output logic [CNT_W-1:0]        OUT_count,
    input  logic [NUM_WB-1:0]       IN_wbValid,
    input  logic [NUM_WB*TAG_W-1:0] IN_wbTag,
    input  logic [NUM_WB*32-1:0]    IN_wbData,
    input  logic                    IN_branchTaken,
    input  logic [SQN_W-1:0]        IN_branchSqN,
    input  logic                    IN_unitBusy,
    output logic                    OUT_valid,
    output logic [5:0]              OUT_opcode,
    output logic [31:0]             OUT_srcA,
    output logic [31:0]             OUT_srcB,
    output logic [TAG_W-1:0]        OUT_tagDst,
    output logic [4:0]              OUT_nmDst,
    output logic [SQN_W-1:0]        OUT_sqN
);

    // Sequence numbers wrap, so age is the sign of the modular difference.
    function automatic logic sqn_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return $signed(d) > 0;
    endfunction

    function automatic logic sqn_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return $signed(d) < 0;
    endfunction

    // Returns {hit, data}; scanning downwards lets the lowest matching port win.
    function automatic logic [32:0] wb_snoop(input logic [TAG_W-1:0] tag,
                                             input logic [NUM_WB-1:0] v,
                                             input logic [NUM_WB*TAG_W-1:0] t,
                                             input logic [NUM_WB*32-1:0] d);
        logic [32:0] r;
        r = '0;
        for (int p = NUM_WB - 1; p >= 0; p--) begin
            if (v[p] && t[p*TAG_W +: TAG_W] == tag) r = {1'b1, d[p*32 +: 32]};
        end
        return r;
    endfunction

    logic             ent_valid_reg [DEPTH];
    logic             ent_rdy_a_reg [DEPTH];
    logic             ent_rdy_b_reg [DEPTH];
    logic [31:0]      ent_data_a_reg[DEPTH];
    logic [31:0]      ent_data_b_reg[DEPTH];
    logic [TAG_W-1:0] ent_tag_a_reg [DEPTH];
    logic [TAG_W-1:0] ent_tag_b_reg [DEPTH];
    logic [5:0]       ent_op_reg    [DEPTH];
    logic [TAG_W-1:0] ent_dst_reg   [DEPTH];
    logic [4:0]       ent_nm_reg    [DEPTH];
    logic [SQN_W-1:0] ent_sqn_reg   [DEPTH];

    logic [32:0]      snoop_a       [DEPTH];
    logic [32:0]      snoop_b       [DEPTH];
    logic             ent_flush     [DEPTH];
    logic             ent_valid_next[DEPTH];

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [32:0]      in_snoop_a;
    logic [32:0]      in_snoop_b;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             enq_fire;
    logic             issue_fire;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign snoop_a[gi]   = wb_snoop(ent_tag_a_reg[gi], IN_wbValid, IN_wbTag, IN_wbData);
            assign snoop_b[gi]   = wb_snoop(ent_tag_b_reg[gi], IN_wbValid, IN_wbTag, IN_wbData);
            assign ent_flush[gi] = IN_branchTaken && sqn_younger(ent_sqn_reg[gi], IN_branchSqN);
        end
    endgenerate

    assign in_snoop_a = wb_snoop(IN_tagA, IN_wbValid, IN_wbTag, IN_wbData);
    assign in_snoop_b = wb_snoop(IN_tagB, IN_wbValid, IN_wbTag, IN_wbData);
    assign OUT_full   = (count_reg == CNT_W'(DEPTH));
    assign OUT_count  = count_reg;

    // Lowest free slot, judged on current state so a slot freed by this cycle's issue stays busy.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_valid_reg[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Oldest entry with both operands ready; strict compare keeps the lower index on a tie.
    always_comb begin
        logic [SQN_W-1:0] best_sqn;
        sel_found = 1'b0;
        sel_idx   = '0;
        best_sqn  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_reg[i] && ent_rdy_a_reg[i] && ent_rdy_b_reg[i] &&
                (!sel_found || sqn_older(ent_sqn_reg[i], best_sqn))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_sqn  = ent_sqn_reg[i];
            end
        end
    end

    assign enq_fire   = IN_valid && !OUT_full && free_found &&
                        !(IN_branchTaken && sqn_younger(IN_sqN, IN_branchSqN));
    assign issue_fire = sel_found && !IN_unitBusy && !ent_flush[sel_idx];

    // Next occupancy after issue, flush and enqueue; the count is its population.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid_next[i] = (ent_valid_reg[i] && !ent_flush[i] &&
                                 !(issue_fire && sel_idx == IDX_W'(i))) ||
                                (enq_fire && free_idx == IDX_W'(i));
            count_next = count_next + CNT_W'(ent_valid_next[i]);
        end
    end

    // Entry storage: enqueue writes, otherwise waiting operands capture wakeup data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_reg[i]  <= 1'b0;
                ent_rdy_a_reg[i]  <= 1'b0;
                ent_rdy_b_reg[i]  <= 1'b0;
                ent_data_a_reg[i] <= '0;
                ent_data_b_reg[i] <= '0;
                ent_tag_a_reg[i]  <= '0;
                ent_tag_b_reg[i]  <= '0;
                ent_op_reg[i]     <= '0;
                ent_dst_reg[i]    <= '0;
                ent_nm_reg[i]     <= '0;
                ent_sqn_reg[i]    <= '0;
            end
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_reg[i] <= ent_valid_next[i];
                if (enq_fire && free_idx == IDX_W'(i)) begin
                    ent_rdy_a_reg[i]  <= IN_availA | in_snoop_a[32];
                    ent_rdy_b_reg[i]  <= IN_availB | in_snoop_b[32];
                    ent_data_a_reg[i] <= IN_availA ? IN_srcA : in_snoop_a[31:0];
                    ent_data_b_reg[i] <= IN_availB ? IN_srcB : in_snoop_b[31:0];
                    ent_tag_a_reg[i]  <= IN_tagA;
                    ent_tag_b_reg[i]  <= IN_tagB;
                    ent_op_reg[i]     <= IN_opcode;
                    ent_dst_reg[i]    <= IN_tagDst;
                    ent_nm_reg[i]     <= IN_nmDst;
                    ent_sqn_reg[i]    <= IN_sqN;
                end else begin
                    if (!ent_rdy_a_reg[i] && snoop_a[i][32]) begin
                        ent_rdy_a_reg[i]  <= 1'b1;
                        ent_data_a_reg[i] <= snoop_a[i][31:0];
                    end
                    if (!ent_rdy_b_reg[i] && snoop_b[i][32]) begin
                        ent_rdy_b_reg[i]  <= 1'b1;
                        ent_data_b_reg[i] <= snoop_b[i][31:0];
                    end
                end
            end
        end
    end

    // Issue register: holds a uop for exactly one cycle, no backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_valid  <= 1'b0;
            OUT_opcode <= '0;
            OUT_srcA   <= '0;
            OUT_srcB   <= '0;
            OUT_tagDst <= '0;
            OUT_nmDst  <= '0;
            OUT_sqN    <= '0;
        end else if (issue_fire) begin
            OUT_valid  <= 1'b1;
            OUT_opcode <= ent_op_reg[sel_idx];
            OUT_srcA   <= ent_data_a_reg[sel_idx];
            OUT_srcB   <= ent_data_b_reg[sel_idx];
            OUT_tagDst <= ent_dst_reg[sel_idx];
            OUT_nmDst  <= ent_nm_reg[sel_idx];
            OUT_sqN    <= ent_sqn_reg[sel_idx];
        end else begin
            OUT_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_issue_queue.sv
// Randomized bench for mul_issue_queue against a transaction-level model that
// keeps live uops in a queue with unwrapped sequence numbers.
module tb_mul_issue_queue;

    localparam int DEPTH  = 4;
    localparam int NUM_WB = 2;
    localparam int TAG_W  = 7;
    localparam int SQN_W  = 7;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [5:0]              in_opcode;
    logic [31:0]             in_src_a, in_src_b;
    logic [TAG_W-1:0]        in_tag_a, in_tag_b, in_tag_dst;
    logic                    in_avail_a, in_avail_b;
    logic [4:0]              in_nm_dst;
    logic [SQN_W-1:0]        in_sqn;
    logic                    out_full;
    logic [2:0]              out_count;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*32-1:0]    wb_data;
    logic                    br_taken;
    logic [SQN_W-1:0]        br_sqn;
    logic                    unit_busy;
    logic                    out_valid;
    logic [5:0]              out_opcode;
    logic [31:0]             out_src_a, out_src_b;
    logic [TAG_W-1:0]        out_tag_dst;
    logic [4:0]              out_nm_dst;
    logic [SQN_W-1:0]        out_sqn;

    mul_issue_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .TAG_W(TAG_W), .SQN_W(SQN_W)) dut (
        .clk(clk), .rst(rst),
        .IN_valid(in_valid), .IN_opcode(in_opcode),
        .IN_srcA(in_src_a), .IN_srcB(in_src_b),
        .IN_tagA(in_tag_a), .IN_tagB(in_tag_b),
        .IN_availA(in_avail_a), .IN_availB(in_avail_b),
        .IN_tagDst(in_tag_dst), .IN_nmDst(in_nm_dst), .IN_sqN(in_sqn),
        .OUT_full(out_full), .OUT_count(out_count),
        .IN_wbValid(wb_valid), .IN_wbTag(wb_tag), .IN_wbData(wb_data),
        .IN_branchTaken(br_taken), .IN_branchSqN(br_sqn), .IN_unitBusy(unit_busy),
        .OUT_valid(out_valid), .OUT_opcode(out_opcode),
        .OUT_srcA(out_src_a), .OUT_srcB(out_src_b),
        .OUT_tagDst(out_tag_dst), .OUT_nmDst(out_nm_dst), .OUT_sqN(out_sqn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned seq;
        logic [5:0]  op;
        logic        ra, rb;
        logic [31:0] da, db;
        logic [6:0]  ta, tb, dst;
        logic [4:0]  nm;
    } uop_t;

    uop_t        model_q[$];
    uop_t        model_out;
    logic        model_valid;
    int unsigned next_seq;
    int unsigned br_seq;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] ref_snoop(input logic [6:0] tag);
        for (int p = 0; p < NUM_WB; p++)
            if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == tag) return {1'b1, wb_data[p*32 +: 32]};
        return 33'd0;
    endfunction

    function automatic logic flushed(input int unsigned seq);
        return br_taken && (seq > br_seq);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        uop_t nq[$];
        uop_t e;
        logic [32:0] s;
        int   ci = -1;
        logic full = (model_q.size() == DEPTH);
        logic iss;
        foreach (model_q[i])
            if (model_q[i].ra && model_q[i].rb && (ci < 0 || model_q[i].seq < model_q[ci].seq)) ci = i;
        iss = (ci >= 0) && !unit_busy && !flushed(model_q[ci].seq);
        model_valid = iss;
        if (iss) model_out = model_q[ci];
        foreach (model_q[i]) begin
            if (!(iss && i == ci) && !flushed(model_q[i].seq)) begin
                e = model_q[i];
                if (!e.ra) begin s = ref_snoop(e.ta); if (s[32]) begin e.ra = 1; e.da = s[31:0]; end end
                if (!e.rb) begin s = ref_snoop(e.tb); if (s[32]) begin e.rb = 1; e.db = s[31:0]; end end
                nq.push_back(e);
            end
        end
        if (in_valid && !full && !flushed(next_seq)) begin
            e.seq = next_seq; e.op = in_opcode; e.ta = in_tag_a; e.tb = in_tag_b;
            e.dst = in_tag_dst; e.nm = in_nm_dst;
            s = ref_snoop(in_tag_a); e.ra = in_avail_a | s[32]; e.da = in_avail_a ? in_src_a : s[31:0];
            s = ref_snoop(in_tag_b); e.rb = in_avail_b | s[32]; e.db = in_avail_b ? in_src_b : s[31:0];
            nq.push_back(e);
        end
        model_q = nq;
    endtask

    task automatic compare_outputs();
        check("out_valid", 64'(out_valid), 64'(model_valid));
        if (model_valid) begin
            check("out_srcA",   64'(out_src_a),   64'(model_out.da));
            check("out_srcB",   64'(out_src_b),   64'(model_out.db));
            check("out_sqN",    64'(out_sqn),     64'(model_out.seq[6:0]));
            check("out_opcode", 64'(out_opcode),  64'(model_out.op));
            check("out_tagDst", 64'(out_tag_dst), 64'(model_out.dst));
            check("out_nmDst",  64'(out_nm_dst),  64'(model_out.nm));
        end
        check("out_count", 64'(out_count), 64'(model_q.size()));
        check("out_full",  64'(out_full),  64'(model_q.size() == DEPTH));
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_opcode = 0; in_src_a = 0; in_src_b = 0; in_tag_a = 0; in_tag_b = 0;
        in_avail_a = 0; in_avail_b = 0; in_tag_dst = 0; in_nm_dst = 0; in_sqn = 0;
        wb_valid = 0; wb_tag = 0; wb_data = 0; br_taken = 0; br_sqn = 0; br_seq = 0; unit_busy = 0;
    endtask

    // Randomize one cycle of dispatch, wakeup, flush and stall inputs.
    task automatic random_inputs(input int cyc, input logic force_ready);
        int unsigned oldest = next_seq;
        int wb_pct = ((cyc / 64) % 3 == 0) ? 8 : 50;
        foreach (model_q[i]) if (model_q[i].seq < oldest) oldest = model_q[i].seq;
        in_valid   = force_ready || (($urandom_range(0, 99) < 65) && (next_seq - oldest < 48));
        in_opcode  = 6'($urandom_range(0, 3));
        in_src_a   = $urandom;
        in_src_b   = $urandom;
        in_tag_a   = 7'($urandom_range(0, 7));
        in_tag_b   = 7'($urandom_range(0, 7));
        in_avail_a = force_ready || ($urandom_range(0, 1) == 1);
        in_avail_b = force_ready || ($urandom_range(0, 1) == 1);
        in_tag_dst = 7'($urandom);
        in_nm_dst  = 5'($urandom);
        in_sqn     = next_seq[6:0];
        for (int p = 0; p < NUM_WB; p++) begin
            wb_valid[p] = ($urandom_range(0, 99) < wb_pct);
            wb_tag[p*TAG_W +: TAG_W] = 7'($urandom_range(0, 7));
            wb_data[p*32 +: 32] = $urandom;
        end
        br_taken  = !force_ready && ($urandom_range(0, 99) < 6);
        br_seq    = next_seq - $urandom_range(0, 10);
        br_sqn    = br_seq[6:0];
        unit_busy = !force_ready && ($urandom_range(0, 99) < 25);
    endtask

    task automatic run_cycle(input int cyc, input logic force_ready);
        random_inputs(cyc, force_ready);
        model_step();
        if (in_valid) next_seq++;
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        logic caught;
        idle_inputs();
        next_seq    = 100;
        model_valid = 0;
        rst = 1'b0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_srcA",  64'(out_src_a), 64'd0);
        check("rst_sqN",   64'(out_sqn),   64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_full",  64'(out_full),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 1500; c++) run_cycle(c, 1'b0);

        // Catch a uop in the output register, then pull reset mid-cycle.
        caught = 0;
        for (int c = 0; c < 20 && !caught; c++) begin
            run_cycle(c, 1'b1);
            caught = model_valid;
        end
        check("rst_setup", 64'(caught), 64'd1);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(out_count), 64'd0);
        idle_inputs();
        model_q.delete();
        model_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_count", 64'(out_count), 64'd0);
        check("post_rst_valid", 64'(out_valid), 64'd0);

        for (int c = 0; c < 300; c++) run_cycle(c + 64, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
